cache_2vias_ctrl: RTL and testbench

Two-way set-associative, write-back, write-allocate cache controller with 1-bit LRU per set, sitting between the user-request front end and the slow main-memory model. Its 3-bit read-data output and its 3-bit hit counter drive the 3-bit seven-segment decoder stage directly, so results and hit statistics appear on the board displays. All state lives in registers; main memory is reached through a request/acknowledge handshake.

---
 rtl/cache_2vias_ctrl.sv | 136 +++++++++++++
 tb/tb_cache_2vias_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cache_2vias_ctrl.sv
// cache_2vias_ctrl: two-way set-associative write-back cache controller, 1-bit LRU per set
module cache_2vias_ctrl #(
  parameter int N_CONJ = 4,
  parameter int TAG_W = 3,
  parameter int DATA_W = 3,
  localparam int IDX_W = $clog2(N_CONJ),
  localparam int AW = TAG_W + IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              acerto,
  output logic [2:0]        contador_acertos,
  output logic              ocupado,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [1:0] {OCIOSO, COMPARA, GRAVA_MEM, ALOCA} state_t;
  state_t state, nxt;
  logic [1:0]        valid  [N_CONJ];
  logic [1:0]        dirty  [N_CONJ];
  logic [TAG_W-1:0]  tag_m  [N_CONJ][2];
  logic [DATA_W-1:0] data_m [N_CONJ][2];
  logic [N_CONJ-1:0] lru;
  logic [AW-1:0]     a_q;
  logic              we_q, fill, vic_q, ac_q;
  logic [DATA_W-1:0] wd_q, rd_q;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tg;
  logic              h0, h1, hit, hw, vic, ack;
  logic [DATA_W-1:0] hit_data;
  always_comb begin
    idx = a_q[IDX_W-1:0];
    tg = a_q[AW-1:IDX_W];
    h0 = valid[idx][0] && tag_m[idx][0] == tg;
    h1 = valid[idx][1] && tag_m[idx][1] == tg;
    hit = h0 || h1;
    hw = ~h0;
    vic = !valid[idx][0] ? 1'b0 : !valid[idx][1] ? 1'b1 : lru[idx];
    ack = mem_req && mem_ack;
    ready = state == COMPARA && hit;
    hit_data = we_q ? wd_q : data_m[idx][hw];
    // results are visible during the ready cycle itself, then held
    rdata = ready ? hit_data : rd_q;
    acerto = ready ? ~fill : ac_q;
    ocupado = state != OCIOSO;
    nxt = state;
    case (state)
      OCIOSO:    nxt = req ? COMPARA : OCIOSO;
      COMPARA:   nxt = hit ? OCIOSO : (valid[idx][vic] && dirty[idx][vic]) ? GRAVA_MEM : ALOCA;
      GRAVA_MEM: nxt = ack ? ALOCA : GRAVA_MEM;
      ALOCA:     nxt = ack ? COMPARA : ALOCA;
      default:   nxt = OCIOSO;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= OCIOSO;
    else state <= nxt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < N_CONJ; i++) begin
        valid[i] <= '0;
        dirty[i] <= '0;
        for (int j = 0; j < 2; j++) begin
          tag_m[i][j] <= '0;
          data_m[i][j] <= '0;
        end
      end
      lru <= '0;
      a_q <= '0;
      we_q <= 1'b0;
      wd_q <= '0;
      rd_q <= '0;
      ac_q <= 1'b0;
      fill <= 1'b0;
      vic_q <= 1'b0;
      contador_acertos <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else
      case (state)
        OCIOSO:
          if (req) begin
            a_q <= addr;
            we_q <= we;
            wd_q <= wdata;
          end
        COMPARA:
          if (hit) begin
            rd_q <= hit_data;
            ac_q <= ~fill;
            if (!fill) contador_acertos <= contador_acertos + 3'd1;
            fill <= 1'b0;
            lru[idx] <= ~hw;
            if (we_q) begin
              data_m[idx][hw] <= wd_q;
              dirty[idx][hw] <= 1'b1;
            end
          end else vic_q <= vic;
        GRAVA_MEM:
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we <= 1'b1;
            mem_addr <= {tag_m[idx][vic_q], idx};
            mem_wdata <= data_m[idx][vic_q];
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            dirty[idx][vic_q] <= 1'b0;
          end
        ALOCA:
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= a_q;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            data_m[idx][vic_q] <= mem_rdata;
            tag_m[idx][vic_q] <= tg;
            valid[idx][vic_q] <= 1'b1;
            dirty[idx][vic_q] <= 1'b0;
            fill <= 1'b1;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_cache_2vias_ctrl.sv
// tb_cache_2vias_ctrl: directed checks of the two-way cache controller against a small memory model
module tb_cache_2vias_ctrl;
  logic clock = 0, reset = 1, req = 0, we = 0, mem_ack = 0;
  logic [4:0] addr = 0;
  logic [2:0] wdata = 0, mem_rdata = 0;
  logic ready, acerto, ocupado, mem_req, mem_we;
  logic [2:0] rdata, contador_acertos, mem_wdata;
  logic [4:0] mem_addr;
  logic [2:0] mem [32];
  int n_cmp = 0, n_err = 0;
  int cyc, nfill, nwb, nready;
  bit got;
  logic [2:0] rd, wb_data;
  logic ac;
  logic [4:0] fill_addr, wb_addr;

  cache_2vias_ctrl dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .acerto(acerto), .contador_acertos(contador_acertos),
    .ocupado(ocupado), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tg, obs, exp);
    end
  endtask

  // one request; the memory model acks on the 2nd cycle mem_req is high
  task automatic access(input logic w, input logic [4:0] a, input logic [2:0] d, input bit hold, input bit spur);
    int wc;
    wc = 0; got = 0; nfill = 0; nwb = 0; cyc = 0;
    req = 1; we = w; addr = a; wdata = d;
    tick();
    if (!hold) req = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      if (ready) begin
        got = 1; cyc = c; rd = rdata; ac = acerto; req = 0;
      end else if (mem_req) begin
        wc++;
        if (wc == 2) begin
          wc = 0;
          mem_ack = 1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata; nwb++; wb_addr = mem_addr; wb_data = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr]; nfill++; fill_addr = mem_addr;
          end
        end
      end else if (spur && c == 2) mem_ack = 1;
      tick();
      mem_ack = 0;
    end
    chk("ready_seen", got, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 3'd0;
    mem[5] = 3'b110; mem[9] = 3'd3; mem[13] = 3'd4; mem[6] = 3'd1; mem[22] = 3'd2;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_acerto", acerto, 0);
    chk("rst_cnt", contador_acertos, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ocupado", ocupado, 0);
    // cold read then re-read
    access(0, 5'b00101, 0, 0, 0);
    chk("cold_nfill", nfill, 1);
    chk("cold_addr", fill_addr, 5'b00101);
    chk("cold_rd", rd, 3'b110);
    chk("cold_ac", ac, 0);
    chk("cold_cnt", contador_acertos, 0);
    chk("cold_idle", ocupado, 0);
    access(0, 5'b00101, 0, 0, 0);
    chk("rehit_cyc", cyc, 1);
    chk("rehit_ac", ac, 1);
    chk("rehit_rd", rd, 3'b110);
    chk("rehit_cnt", contador_acertos, 1);
    chk("rehit_nfill", nfill, 0);
    // LRU eviction in set 1
    access(0, 5'b01001, 0, 0, 0);
    chk("t2_nfill", nfill, 1);
    chk("t2_rd", rd, 3);
    access(0, 5'b00101, 0, 0, 0);
    chk("t1_hit", ac, 1);
    access(0, 5'b01101, 0, 0, 0);
    chk("t3_nwb", nwb, 0);
    chk("t3_nfill", nfill, 1);
    chk("t3_addr", fill_addr, 5'b01101);
    chk("t3_rd", rd, 4);
    access(0, 5'b00101, 0, 0, 0);
    chk("t1_kept_cyc", cyc, 1);
    chk("t1_kept_ac", ac, 1);
    chk("lru_cnt", contador_acertos, 3);
    // dirty write-back of tag 1
    access(1, 5'b00101, 3'b011, 0, 0);
    chk("wr_ac", ac, 1);
    chk("wr_rd", rd, 3'b011);
    chk("wr_nfill", nfill, 0);
    chk("wr_cnt", contador_acertos, 4);
    access(0, 5'b01101, 0, 0, 0);
    chk("t3_hit", ac, 1);
    access(0, 5'b01001, 0, 0, 0);
    chk("wb_nwb", nwb, 1);
    chk("wb_addr", wb_addr, 5'b00101);
    chk("wb_data", wb_data, 3'b011);
    chk("wb_nfill", nfill, 1);
    chk("wb_rd", rd, 3);
    chk("wb_ac", ac, 0);
    access(0, 5'b00101, 0, 0, 0);
    chk("refetch_nfill", nfill, 1);
    chk("refetch_nwb", nwb, 0);
    chk("refetch_rd", rd, 3'b011);
    chk("refetch_ac", ac, 0);
    chk("refetch_cnt", contador_acertos, 5);
    // reset while ALOCA waits for mem_ack
    req = 1; we = 0; addr = 5'b00110;
    tick();
    req = 0;
    tick(); tick();
    chk("aloca_mem_req", mem_req, 1);
    chk("aloca_mem_addr", mem_addr, 5'b00110);
    #2 reset = 1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_ocupado", ocupado, 0);
    chk("arst_ready", ready, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_acerto", acerto, 0);
    chk("arst_cnt", contador_acertos, 0);
    chk("arst_mem_addr", mem_addr, 0);
    #1 reset = 0;
    tick();
    mem_ack = 1; mem_rdata = 3'd7;
    tick();
    mem_ack = 0;
    chk("late_ack_ocupado", ocupado, 0);
    chk("late_ack_mem_req", mem_req, 0);
    access(0, 5'b00110, 0, 0, 0);
    chk("post_rst_nfill", nfill, 1);
    chk("post_rst_ac", ac, 0);
    chk("post_rst_rd", rd, 1);
    chk("post_rst_cnt", contador_acertos, 0);
    // counter wrap over 9 hits
    for (int i = 0; i < 8; i++) access(0, 5'b00110, 0, 0, 0);
    chk("wrap8_cnt", contador_acertos, 0);
    chk("wrap8_ac", ac, 1);
    access(0, 5'b00110, 0, 0, 0);
    chk("wrap9_cnt", contador_acertos, 1);
    // req held through a miss plus a spurious mem_ack
    access(0, 5'b10110, 0, 1, 1);
    chk("busy_nfill", nfill, 1);
    chk("busy_nwb", nwb, 0);
    chk("busy_rd", rd, 2);
    chk("busy_ac", ac, 0);
    nready = 0;
    for (int i = 0; i < 3; i++) begin
      if (ready) nready++;
      tick();
    end
    chk("busy_extra_ready", nready, 0);
    chk("busy_idle", ocupado, 0);
    chk("busy_cnt", contador_acertos, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
